alu_seq_driver: RTL

Initiator for the 4-bit sequential ALU pin interface. Accepts one complete operation (opcode, operand A, operand B) on a valid/ready command port and serializes it as three nibbles on the ALU `data`/`enabled` pins. After a fixed latency it captures the ALU's `result` and `flags` nibbles and returns them on a valid/ready response port. Sits between on-chip control logic, or a bring-up sequencer, and the ALU's `io_in`/`io_out` wiring.

---
 rtl/alu_seq_driver.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_driver.sv
// Command-to-pin driver for the 4-bit sequential ALU: serializes op/A/B nibbles, then captures result/flags.
// Optional ALU_SEQ_DRV_TXN_COUNT_EN adds an 8-bit completed-transaction counter on port txn_count.
module alu_seq_driver #(
  parameter int RESULT_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic       alu_enabled,
  output logic [3:0] alu_data,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic       busy
`ifdef ALU_SEQ_DRV_TXN_COUNT_EN
  ,output logic [7:0] txn_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_A,
    S_B,
    S_WAIT,
    S_RSP
  } state_e;

  localparam logic [3:0] WaitLoad = 4'(RESULT_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rsp_result_q, rsp_result_d;
  logic [3:0] rsp_flags_q, rsp_flags_d;
`ifdef ALU_SEQ_DRV_TXN_COUNT_EN
  logic [7:0] txn_count_q, txn_count_d;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
`ifdef ALU_SEQ_DRV_TXN_COUNT_EN
    txn_count_d  = txn_count_q;
`endif
    case (state_q)
      S_IDLE: begin
        // Operands are snapshotted here so later cmd_* changes cannot leak into the beats.
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = S_OP;
        end
      end
      S_OP: state_d = S_A;
      S_A:  state_d = S_B;
      S_B: begin
        cnt_d   = WaitLoad;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = alu_flags;
          state_d      = S_RSP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
`ifdef ALU_SEQ_DRV_TXN_COUNT_EN
          txn_count_d = txn_count_q + 8'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rsp_result_q <= 4'd0;
      rsp_flags_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    cnt_q <= cnt_d;
  end

`ifdef ALU_SEQ_DRV_TXN_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) txn_count_q <= 8'd0;
    else       txn_count_q <= txn_count_d;
  end

  assign txn_count = txn_count_q;
`endif

  // Every output is a decode of registered state; no input reaches an output combinationally.
  always_comb begin
    alu_data = 4'd0;
    case (state_q)
      S_OP:    alu_data = op_q;
      S_A:     alu_data = a_q;
      S_B:     alu_data = b_q;
      default: alu_data = 4'd0;
    endcase
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign alu_enabled = (state_q == S_OP) || (state_q == S_A) || (state_q == S_B);
  assign rsp_valid   = (state_q == S_RSP);
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;

endmodule
